// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: one full-adder cell plus a carry flip-flop process one
//   bit per clock, LSB first. An operation takes WIDTH cycles in RUN, then a
//   single DONE cycle, then back to IDLE.
//
//   Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port. When
//   sub=1 is captured, B is inverted and the initial carry forced to 1, giving
//   Sum = A - B mod 2^WIDTH with Cout=1 meaning "no borrow".
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 in IDLE
//   captures the operands. busy is high for the WIDTH RUN cycles, done pulses
//   for exactly one cycle when Sum/Cout take the new result. start seen in RUN
//   or DONE is ignored; a start held high is accepted in the IDLE cycle after
//   DONE.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an operation (IDLE only)
//   A, B   in   WIDTH-bit operands, captured on the accepting edge
//   Cin    in   carry-in, captured on the accepting edge
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  high while in RUN
//   done   out  one-cycle pulse with a new result
//   Sum    out  registered result of the last completed operation
//   Cout   out  registered carry-out of the last completed operation
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // The single full-adder cell works on the LSBs of the shift registers.
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] s_next;

    assign fa_s   = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign s_next = {fa_s, s_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
`ifdef SERIAL_ADDER_SUB_EN
                        // Two's complement subtract: A + ~B + 1, Cin ignored.
                        b_sh  <= sub ? ~B : B;
                        carry <= sub ? 1'b1 : Cin;
`else
                        b_sh  <= B;
                        carry <= Cin;
`endif
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Sum   <= s_next;
                        Cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Two instances share clock and reset: an 8-bit one for the directed cases
//   and a 16-bit one for the random regression. Expected results come from
//   plain integer arithmetic and are queued at the accepting edge, then popped
//   and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16),
        .A(a16), .B(b16), .Cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub16),
`endif
        .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16)
    );

    // ---------------- scoreboard ----------------
    logic [8:0]  exp_q8[$];
    logic [16:0] exp_q16[$];
    logic [8:0]  last8  = '0;
    logic [16:0] last16 = '0;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {carry-out, sum} of a w-bit add or two's complement subtract.
    function automatic longint unsigned ref_op(input int w, input longint unsigned a,
                                               input longint unsigned b, input bit cin,
                                               input bit sb);
        longint unsigned mask;
        longint unsigned t;
        mask = (64'd1 << w) - 1;
        if (sb) t = a + ((~b) & mask) + 1;
        else    t = a + b + cin;
        return t & ((64'd1 << (w + 1)) - 1);
    endfunction

    // ---------------- 8-bit driver ----------------
    // Called and returning 1 time unit after a rising edge.
    task automatic wait_done8();
        int lat;
        int bsy;
        logic [8:0] exp;
        lat = 0;
        bsy = busy8 ? 1 : 0;
        while (!done8 && lat < 40) begin
            check("hold8", {cout8, sum8}, last8);
            @(posedge clk); #1;
            lat++;
            if (busy8) bsy++;
        end
        check("lat8", lat, 8);
        check("busy8", bsy, 8);
        exp = exp_q8.pop_front();
        check("res8", {cout8, sum8}, exp);
        last8 = exp;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sb);
        a8 = a; b8 = b; cin8 = cin; sub8 = sb; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        exp_q8.push_back(9'(ref_op(8, a, b, cin, sb)));
        wait_done8();
        @(posedge clk); #1;
        check("pulse8", done8, 1'b0);
    endtask

    // ---------------- 16-bit driver ----------------
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sb);
        int lat;
        logic [16:0] exp;
        a16 = a; b16 = b; cin16 = cin; sub16 = sb; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        exp_q16.push_back(17'(ref_op(16, a, b, cin, sb)));
        // Scramble operands during RUN: they must not matter.
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        lat = 0;
        while (!done16 && lat < 80) begin
            if ({cout16, sum16} !== last16) check("hold16", {cout16, sum16}, last16);
            @(posedge clk); #1;
            lat++;
        end
        check("lat16", lat, 16);
        exp = exp_q16.pop_front();
        check("res16", {cout16, sum16}, exp);
        last16 = exp;
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic sb;
        repeat (3) @(posedge clk);
        #1;
        check("rst8", {busy8, done8, cout8, sum8}, 11'd0);
        check("rst16", {busy16, done16, cout16, sum16}, 19'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic and wrap-around cases.
        op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        check("dir_5a3c", {cout8, sum8}, 9'h096);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        check("dir_ff01", {cout8, sum8}, 9'h100);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("dir_ffff1", {cout8, sum8}, 9'h1FF);
        op8(8'h00, 8'h00, 1'b0, 1'b0);
        check("dir_zero", {cout8, sum8}, 9'h000);

        // Operands changed and start held during RUN; start kept high through DONE.
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        exp_q8.push_back(9'h033);
        a8 = 8'h33; b8 = 8'h44;
        wait_done8();
        check("held_res", {cout8, sum8}, 9'h033);
        exp_q8.push_back(9'h077);
        @(posedge clk); #1;
        check("held_idle", {busy8, done8}, 2'b00);
        @(posedge clk); #1;
        check("held_accept", busy8, 1'b1);
        start8 = 1'b0;
        wait_done8();
        check("held_res2", {cout8, sum8}, 9'h077);
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_busy", busy8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst", {busy8, done8, cout8, sum8}, 11'd0);
        @(negedge clk); rst_n = 1'b1;
        last8 = '0;
        last16 = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) check("no_done", done8, 1'b0);
        end
        check("post_rst_idle", {busy8, done8, cout8, sum8}, 11'd0);
        op8(8'h01, 8'h02, 1'b0, 1'b0);
        check("post_rst", {cout8, sum8}, 9'h003);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h10, 8'h01, 1'b0, 1'b1);
        check("sub_1001", {cout8, sum8}, 9'h10F);
        op8(8'h01, 8'h02, 1'b1, 1'b1);
        check("sub_0102", {cout8, sum8}, 9'h0FF);
`endif

        // Short random run on the 8-bit instance.
        for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), sb);
        end

        // 16-bit regression, with a few corners first.
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        op16(16'h8000, 16'h8000, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), sb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 Port: B  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 Port: Cin  input  1  carry-in, captured on the accepting edge.
REQ-008 Port: sub  input  1  subtract select, captured on the accepting edge; present only when SERIAL_ADDER_SUB_EN is defined.
REQ-009 Port: busy  output  1  high while an operation is in progress (RUN state).
REQ-010 Port: done  output  1  single-cycle pulse marking a new valid result.
REQ-011 Port: Sum  output  WIDTH  registered result of the last completed operation.
REQ-012 Port: Cout  output  1  registered carry-out of the last completed operation.

Function
REQ-013 The block SHALL add bit-serially, one bit per clock, LSB first, using a single 1-bit full-adder cell and a carry flip-flop.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits.
REQ-015 In IDLE with start=1, the edge SHALL capture A, B and Cin into internal shift/carry registers, clear the bit counter, and move to RUN.
REQ-016 In RUN, each edge SHALL process bit index = counter: sum bit = a^b^c; carry = majority(a,b,c); counter increments.
REQ-017 On the edge that processes bit WIDTH-1, the FSM SHALL load Sum and Cout with the full result and move to DONE.
REQ-018 DONE SHALL last exactly one cycle and return unconditionally to IDLE.
REQ-019 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-020 Latency: done SHALL be high in the cycle that begins WIDTH edges after the start-accepting edge.
REQ-021 Back-to-back operations: a start held high SHALL be accepted in the first IDLE cycle after DONE, giving one operation per WIDTH+2 cycles.
REQ-022 start in RUN or DONE SHALL be ignored; operands changing during RUN SHALL not affect the result.
REQ-023 Sum and Cout SHALL hold the previous result during RUN and change only on the completing edge.
REQ-024 Wrap-around: the result SHALL be (A+B+Cin) mod 2^WIDTH, with Cout = bit WIDTH of the true sum.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, carry 0, Sum 0, Cout 0, busy 0, done 0.
REQ-026 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow, and Sum/Cout SHALL read 0.
REQ-027 After rst_n rises, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-028 Macro SERIAL_ADDER_SUB_EN SHALL gate a subtract mode.
REQ-029 With the macro defined and sub=1 captured, B SHALL be inverted bitwise and the initial carry forced to 1 (Cin ignored); Sum = A-B mod 2^WIDTH, Cout = 1 means no borrow.
REQ-030 With the macro defined and sub=0, or with the macro undefined, the block SHALL add only; the sub port SHALL not exist when undefined.

Verification
REQ-031 WIDTH=8, A=0x5A, B=0x3C, Cin=0, start for 1 cycle -> done 8 edges later, Sum=0x96, Cout=0, busy high 8 cycles.
REQ-032 A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
REQ-033 start=1 and new operands applied during RUN -> ignored; result matches first operands; start held continuously -> second op begins the cycle after DONE.
REQ-034 rst_n pulsed low at bit 4 of an operation -> outputs 0 at once, no done pulse; next operation A=0x01, B=0x02 -> Sum=0x03.
REQ-035 SERIAL_ADDER_SUB_EN defined, sub=1: A=0x10, B=0x01 -> Sum=0x0F, Cout=1; A=0x01, B=0x02 -> Sum=0xFF, Cout=0.
REQ-036 WIDTH=16 random regression of at least 1000 operations, checked against A+B+Cin -> zero mismatches, done latency always 16.
